// File: rtl/vga_bg_pkg.sv
// rtl/vga_bg_pkg.sv - shared constants and helpers for the background buffer
package vga_bg_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_FRAME  = 2'd2;

    localparam int CTRL_SWAP = 0;
    localparam int CTRL_FCLR = 1;

    localparam int BG_RD_LAT = 2;

    // Little-endian lane select: lane 0 is bits 7:0.
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/bg_dpram.sv
// rtl/bg_dpram.sv - true dual-port RAM, port A byte-writable, port B read-only
module bg_dpram #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic [3:0]    a_be,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wdata,
    output logic [31:0]   a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic [31:0]   b_rdata
);

    logic [3:0][7:0] mem [2**AW];
    logic [31:0]     a_rdata_q;
    logic [31:0]     b_rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (a_we && a_be[i]) begin
                mem[a_addr][i] <= a_wdata[8*i +: 8];
            end
        end
        a_rdata_q <= mem[a_addr];
    end

    always_ff @(posedge clk) begin
        b_rdata_q <= mem[b_addr];
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/vga_bg_buffer.sv
// rtl/vga_bg_buffer.sv - Avalon-MM double-buffered background store with vsync bank swap
module vga_bg_buffer
    import vga_bg_pkg::*;
#(
    parameter int WORD_AW = 14,
    parameter int FC_W    = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               AVL_CS,
    input  logic               AVL_READ,
    input  logic               AVL_WRITE,
    input  logic [WORD_AW:0]   AVL_ADDR,
    input  logic [3:0]         AVL_BYTE_EN,
    input  logic [31:0]        AVL_WRITEDATA,
    output logic [31:0]        AVL_READDATA,
    input  logic               VGA_VS,
    input  logic [15:0]        vga_port_local_addr,
    output logic [7:0]         vga_port_backgrounddata
);

    logic            active_q, active_d;
    logic            swap_pending_q, swap_pending_d;
    logic [FC_W-1:0] frame_count_q, frame_count_d;
    logic            vs_q, vs_prev_q;
    logic            rd_q, rd_ram_q, rd_zero_q;
    logic [31:0]     reg_rdata_q, reg_rdata;
    logic [31:0]     readdata_q, readdata_d;
    logic [1:0]      lane_q;
    logic [7:0]      bg_q;

    logic            acc_wr, acc_rd, acc_both, ram_we, ctrl_we, vs_fall;
    logic [31:0]     ram_a_rdata, ram_b_rdata;

    assign acc_wr   = AVL_CS & AVL_WRITE;
    assign acc_rd   = AVL_CS & AVL_READ & ~AVL_WRITE;
    assign acc_both = AVL_CS & AVL_READ & AVL_WRITE;
    assign ram_we   = acc_wr & ~AVL_ADDR[WORD_AW];
    assign ctrl_we  = acc_wr & AVL_ADDR[WORD_AW] & (AVL_ADDR[1:0] == REG_CTRL);
    assign vs_fall  = vs_prev_q & ~vs_q;

    // Avalon side always sees the back bank, video the front bank.
    bg_dpram #(.AW(WORD_AW + 1)) u_ram (
        .clk     (Clk),
        .a_we    (ram_we),
        .a_be    (AVL_BYTE_EN),
        .a_addr  ({~active_q, AVL_ADDR[WORD_AW-1:0]}),
        .a_wdata (AVL_WRITEDATA),
        .a_rdata (ram_a_rdata),
        .b_addr  ({active_q, vga_port_local_addr[WORD_AW+1:2]}),
        .b_rdata (ram_b_rdata)
    );

    always_comb begin
        reg_rdata = '0;
        case (AVL_ADDR[1:0])
            REG_STATUS: reg_rdata[1:0] = {swap_pending_q, active_q};
            REG_FRAME:  reg_rdata[FC_W-1:0] = frame_count_q;
            default:    reg_rdata = '0;
        endcase
    end

    // The edge consumes the old request before a same-cycle CTRL write can set a new one.
    always_comb begin
        active_d       = active_q ^ (vs_fall & swap_pending_q);
        swap_pending_d = (swap_pending_q & ~vs_fall) | (ctrl_we & AVL_WRITEDATA[CTRL_SWAP]);
        frame_count_d  = frame_count_q + FC_W'(vs_fall);
        if (ctrl_we && AVL_WRITEDATA[CTRL_FCLR]) begin
            frame_count_d = '0;
        end
    end

    always_comb begin
        readdata_d = readdata_q;
        if (rd_q) begin
            readdata_d = rd_ram_q ? ram_a_rdata : reg_rdata_q;
        end else if (rd_zero_q) begin
            readdata_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            active_q       <= 1'b0;
            swap_pending_q <= 1'b0;
            frame_count_q  <= '0;
            vs_q           <= 1'b1;
            vs_prev_q      <= 1'b1;
            rd_q           <= 1'b0;
            rd_ram_q       <= 1'b0;
            rd_zero_q      <= 1'b0;
            reg_rdata_q    <= '0;
            readdata_q     <= '0;
            lane_q         <= '0;
            bg_q           <= '0;
        end else begin
            active_q       <= active_d;
            swap_pending_q <= swap_pending_d;
            frame_count_q  <= frame_count_d;
            vs_q           <= VGA_VS;
            vs_prev_q      <= vs_q;
            rd_q           <= acc_rd;
            rd_ram_q       <= ~AVL_ADDR[WORD_AW];
            rd_zero_q      <= acc_both;
            reg_rdata_q    <= reg_rdata;
            readdata_q     <= readdata_d;
            lane_q         <= vga_port_local_addr[1:0];
            bg_q           <= lane_byte(ram_b_rdata, lane_q);
        end
    end

    assign AVL_READDATA            = readdata_q;
    assign vga_port_backgrounddata = bg_q;

endmodule

// File: tb/tb_vga_bg_buffer.sv
// tb/tb_vga_bg_buffer.sv - scoreboard bench for vga_bg_buffer
module tb_vga_bg_buffer;

    localparam int WORD_AW = 14;
    localparam int FC_W    = 16;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              AVL_CS = 1'b0;
    logic              AVL_READ = 1'b0;
    logic              AVL_WRITE = 1'b0;
    logic [WORD_AW:0]  AVL_ADDR = '0;
    logic [3:0]        AVL_BYTE_EN = '0;
    logic [31:0]       AVL_WRITEDATA = '0;
    logic [31:0]       AVL_READDATA;
    logic              VGA_VS = 1'b1;
    logic [15:0]       vga_port_local_addr = '0;
    logic [7:0]        vga_port_backgrounddata;

    vga_bg_buffer #(.WORD_AW(WORD_AW), .FC_W(FC_W)) dut (
        .Clk                     (Clk),
        .Reset                   (Reset),
        .AVL_CS                  (AVL_CS),
        .AVL_READ                (AVL_READ),
        .AVL_WRITE               (AVL_WRITE),
        .AVL_ADDR                (AVL_ADDR),
        .AVL_BYTE_EN             (AVL_BYTE_EN),
        .AVL_WRITEDATA           (AVL_WRITEDATA),
        .AVL_READDATA            (AVL_READDATA),
        .VGA_VS                  (VGA_VS),
        .vga_port_local_addr     (vga_port_local_addr),
        .vga_port_backgrounddata (vga_port_backgrounddata)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t         avl_sb[$];
    sb_t         vid_sb[$];
    sb_t         mon_a, mon_v;
    logic [1:0]  avl_pipe, vid_pipe;
    logic        vid_en = 1'b0;
    logic [31:0] last_rd_exp;
    int          checks = 0;
    int          errors = 0;

    // Reference model: two banks as a sparse word map plus the three software-visible registers.
    logic [31:0] mem [int];
    logic        m_active = 1'b0;
    logic        m_pending = 1'b0;
    int          m_frame = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    function automatic int key(input logic bank, input int word);
        return (int'(bank) << WORD_AW) | word;
    endfunction

    function automatic logic [31:0] reg_exp(input logic [1:0] off);
        case (off)
            2'd1:    return {30'b0, m_pending, m_active};
            2'd2:    return 32'(m_frame);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            avl_pipe <= '0;
            vid_pipe <= '0;
        end else begin
            avl_pipe <= {avl_pipe[0], AVL_CS & AVL_READ};
            vid_pipe <= {vid_pipe[0], vid_en};
        end
    end

    always @(negedge Clk) begin
        if (Reset) begin
            last_rd_exp = 32'h0;
        end else begin
            if (avl_pipe[1]) begin
                if (avl_sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL avl_sb_underflow actual=%08h expected=none", AVL_READDATA);
                end else begin
                    mon_a = avl_sb.pop_front();
                    check(mon_a.name, AVL_READDATA, mon_a.exp);
                    last_rd_exp = mon_a.exp;
                end
            end else begin
                check("avl_hold", AVL_READDATA, last_rd_exp);
            end
            if (vid_pipe[1]) begin
                if (vid_sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL vid_sb_underflow actual=%02h expected=none", vga_port_backgrounddata);
                end else begin
                    mon_v = vid_sb.pop_front();
                    check(mon_v.name, {24'h0, vga_port_backgrounddata}, mon_v.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0; vid_en = 1'b0;
    endtask

    task automatic model_write(input logic [WORD_AW:0] addr, input logic [3:0] be, input logic [31:0] data);
        int k;
        logic [31:0] w;
        if (!addr[WORD_AW]) begin
            k = key(~m_active, int'(addr[WORD_AW-1:0]));
            w = mem.exists(k) ? mem[k] : 32'h0;
            for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = data[8*i +: 8];
            mem[k] = w;
        end else if (addr[1:0] == 2'd0) begin
            if (data[0]) m_pending = 1'b1;
            if (data[1]) m_frame = 0;
        end
    endtask

    task automatic avl_write(input logic [WORD_AW:0] addr, input logic [3:0] be, input logic [31:0] data);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_READ = 1'b0;
        AVL_ADDR = addr; AVL_BYTE_EN = be; AVL_WRITEDATA = data;
        model_write(addr, be, data);
        tick();
        idle();
    endtask

    task automatic avl_read(input logic [WORD_AW:0] addr, input string name);
        sb_t e;
        e.name = name;
        if (!addr[WORD_AW]) e.exp = mem[key(~m_active, int'(addr[WORD_AW-1:0]))];
        else                e.exp = reg_exp(addr[1:0]);
        avl_sb.push_back(e);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = addr;
        tick();
        idle();
    endtask

    task automatic avl_rdwr(input logic [WORD_AW:0] addr, input logic [31:0] data);
        sb_t e;
        e.name = "rdwr_slot";
        e.exp  = 32'h0;
        avl_sb.push_back(e);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b1;
        AVL_ADDR = addr; AVL_BYTE_EN = 4'hF; AVL_WRITEDATA = data;
        model_write(addr, 4'hF, data);
        tick();
        idle();
    endtask

    task automatic vid_read(input logic [15:0] addr, input string name);
        sb_t e;
        logic [31:0] w;
        w = mem[key(m_active, int'(addr[15:2]))];
        e.name = name;
        e.exp  = {24'h0, w[8*addr[1:0] +: 8]};
        vid_sb.push_back(e);
        vga_port_local_addr = addr;
        vid_en = 1'b1;
        tick();
        vid_en = 1'b0;
    endtask

    // The falling edge becomes visible inside the DUT one cycle after the pin drops.
    task automatic vs_pulse(input bit swap_on_edge);
        VGA_VS = 1'b0;
        tick();
        m_frame = (m_frame + 1) % (1 << FC_W);
        if (m_pending) begin
            m_active  = ~m_active;
            m_pending = 1'b0;
        end
        if (swap_on_edge) begin
            AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_READ = 1'b0;
            AVL_ADDR = (WORD_AW+1)'(1 << WORD_AW); AVL_BYTE_EN = 4'h0; AVL_WRITEDATA = 32'h1;
            m_pending = 1'b1;
            tick();
            idle();
        end else begin
            tick();
        end
        VGA_VS = 1'b1;
        tick();
        tick();
    endtask

    function automatic logic [WORD_AW:0] raddr(input logic [1:0] off);
        logic [WORD_AW:0] a;
        a = '0;
        a[WORD_AW] = 1'b1;
        a[1:0] = off;
        return a;
    endfunction

    initial begin
        logic [WORD_AW:0] a;
        int               w, op;
        logic [3:0]       be;
        logic [15:0]      va;

        tick(); tick();
        Reset = 1'b0;
        tick();
        check("reset_readdata", AVL_READDATA, 32'h0);
        check("reset_bgdata", {24'h0, vga_port_backgrounddata}, 32'h0);
        avl_read(raddr(2'd1), "reset_status");
        avl_read(raddr(2'd2), "reset_frame");

        avl_write(15'd5, 4'hF, 32'hA1B2C3D4);
        avl_write(15'd5, 4'b0010, 32'h0000EE00);
        avl_read(15'd5, "t1_be_merge");

        vs_pulse(0); vs_pulse(0); vs_pulse(0);
        avl_read(raddr(2'd2), "t3_frame3");
        avl_read(raddr(2'd1), "t3_status");
        avl_write(raddr(2'd0), 4'h0, 32'h2);
        avl_read(raddr(2'd2), "t3_frame_clr");

        avl_write(15'd3, 4'hF, 32'h44332211);
        avl_write(raddr(2'd0), 4'h0, 32'h1);
        avl_read(raddr(2'd1), "t2_pending");
        vs_pulse(0);
        avl_read(raddr(2'd1), "t2_status");
        for (int i = 12; i < 16; i++) vid_read(16'(i), "t2_video");
        tick();

        vs_pulse(1);
        avl_read(raddr(2'd1), "t4_edge_req");
        vs_pulse(0);
        avl_read(raddr(2'd1), "t4_next_edge");

        avl_rdwr(15'd7, 32'h12345678);
        avl_read(15'd7, "t6_readback");
        avl_read(raddr(2'd3), "reg3_zero");

        for (int it = 0; it < 400; it++) begin
            op = int'($urandom_range(0, 11));
            w  = int'($urandom_range(0, 15));
            a  = (WORD_AW+1)'(w);
            if (op <= 3) begin
                be = mem.exists(key(~m_active, w)) ? 4'($urandom_range(0, 15)) : 4'hF;
                avl_write(a, be, $urandom);
            end else if (op <= 5) begin
                if (mem.exists(key(~m_active, w))) avl_read(a, "rnd_ram_read");
                else avl_write(a, 4'hF, $urandom);
            end else if (op <= 7) begin
                va = 16'((w << 2) | int'($urandom_range(0, 3)));
                if (mem.exists(key(m_active, w))) vid_read(va, "rnd_video");
                else tick();
            end else if (op == 8) begin
                avl_read(raddr(2'($urandom_range(0, 3))), "rnd_reg_read");
            end else if (op == 9) begin
                avl_write(raddr(2'd0), 4'($urandom), 32'($urandom_range(0, 3)));
            end else if (op == 10) begin
                vs_pulse($urandom_range(0, 1) == 1);
            end else begin
                avl_rdwr(a, $urandom);
            end
        end

        avl_write(raddr(2'd0), 4'h0, 32'h1);
        avl_read(15'd7, "t5_pre_read");
        tick(); tick(); tick();
        #3 Reset = 1'b1;
        #1;
        check("t5_rst_readdata", AVL_READDATA, 32'h0);
        check("t5_rst_bgdata", {24'h0, vga_port_backgrounddata}, 32'h0);
        m_active = 1'b0; m_pending = 1'b0; m_frame = 0;
        avl_sb.delete();
        vid_sb.delete();
        #2 Reset = 1'b0;
        tick();
        avl_read(raddr(2'd1), "t5_status");
        avl_read(raddr(2'd2), "t5_frame");
        vs_pulse(0);
        avl_read(raddr(2'd1), "t5_no_swap");

        tick(); tick(); tick(); tick();
        check("avl_sb_drain", 32'(avl_sb.size()), 32'h0);
        check("vid_sb_drain", 32'(vid_sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_bg_buffer.md
# vga_bg_buffer

Avalon-MM responder and double-buffered on-chip background store for the tank game's video path. The NIOS II writes 8-bit background pixels into a back bank over Avalon-MM. The color mapper reads the front bank through the `vga_port_local_addr` / `vga_port_backgrounddata` conduit. Banks swap only on a software request, at the next vertical sync, so a frame never tears. The block sits inside `lab62_soc` as the component behind the `vga_port` conduit.

## Interface
Parameters:
- `WORD_AW`, default 14: word-address width of one bank (2^14 words × 32 bit = 64 KiB per bank).
- `FC_W`, default 16: frame counter width.

Ports:
- `Clk`  in  1: system clock (50 MHz), the only clock.
- `Reset`  in  1: asynchronous, active-high reset.
- `AVL_CS`  in  1: chip select.
- `AVL_READ`  in  1: read strobe, qualified by `AVL_CS`.
- `AVL_WRITE`  in  1: write strobe, qualified by `AVL_CS`.
- `AVL_ADDR`  in  `WORD_AW+1`: word address. MSB=0 selects the back-bank RAM; MSB=1 selects the registers.
- `AVL_BYTE_EN`  in  4: byte enables.
- `AVL_WRITEDATA`  in  32: write data.
- `AVL_READDATA`  out  32: read data, valid exactly 2 cycles after the read is accepted.
- `VGA_VS`  in  1: vertical sync from `vga_controller`, active low, generated on `Clk`.
- `vga_port_local_addr`  in  16: byte address into the front bank.
- `vga_port_backgrounddata`  out  8: front-bank byte.

## Operation
- Storage is a single dual-port RAM of 2 × 2^`WORD_AW` words.
  - Physical address = {bank, word}.
  - Port A (Avalon) always targets bank `~active`.
  - Port B (video) always targets bank `active`.
- RAM write: `AVL_CS & AVL_WRITE & ~AVL_ADDR[MSB]` writes each byte lane i where `AVL_BYTE_EN[i]=1`. Other lanes are unchanged.
- RAM read: returns the back-bank word.
- Registers, selected by `AVL_ADDR[1:0]` when MSB=1:
  - 0 CTRL (W): writing bit0=1 sets `swap_pending`. Writing bit1=1 clears `frame_count`. Reads return 0.
  - 1 STATUS (R): bit0=`active`, bit1=`swap_pending`, all other bits 0.
  - 2 FRAME (R): zero-extended `frame_count`.
  - 3: reads 0, writes ignored.
  - Byte enables are ignored for register writes.
- Video read: `vga_port_local_addr[15:2]` selects the word (its top bits beyond `WORD_AW` are dropped). `[1:0]` selects the byte lane, little-endian (lane 0 = bits 7:0).
- Vsync handling:
  - `VGA_VS` is registered once; a falling edge is detected on the registered value.
  - On that edge: `frame_count` increments, wrapping at 2^`FC_W`.
  - If `swap_pending` is set on that edge: `active` toggles and `swap_pending` clears.
- Simultaneous events:
  - CTRL swap write in the same cycle as the VS edge: the edge sees the old `swap_pending`, and the new request is set. The swap therefore occurs at the following edge unless one was already pending.
  - CTRL bit1 write in the same cycle as the VS edge: the clear wins, so `frame_count` = 0.
  - `AVL_READ` and `AVL_WRITE` both asserted: the write is performed, the read is ignored, and readdata returns 0 for that slot.
  - Avalon write in the same cycle as a swap: the write uses the `active` value before the swap, i.e. the old back bank.
- Reset values:
  - Outputs: `AVL_READDATA`=0, `vga_port_backgrounddata`=0.
  - Registers: `active`=0, `swap_pending`=0, `frame_count`=0, the VS register=1.
  - RAM contents are not reset.
  - Reset mid-pending discards the pending request.

## Timing
- Avalon side: no waitrequest; every access is accepted in one cycle.
  - Fixed read latency 2: cycle N request, N+1 RAM/register sample, N+2 `AVL_READDATA` valid. Output is held until the next read completes.
  - Back-to-back reads are fully pipelined, one per cycle.
  - A write at cycle N is visible to a read issued at N+1 or later.
- Video side, latency 2: the address is registered at N, the RAM is read at N+1, and the lane-muxed byte is registered onto `vga_port_backgrounddata` at N+2. The color mapper compensates by issuing addresses 2 `Clk` ahead.
- `active` changes 2 cycles after the `VGA_VS` falling edge on the pin: 1 cycle for the input register, 1 for the state update. Video data from the new bank appears 2 cycles after that.

## Structure
- Package `vga_bg_pkg`:
  - Register offsets `REG_CTRL`, `REG_STATUS`, `REG_FRAME`.
  - CTRL bit positions `CTRL_SWAP`, `CTRL_FCLR`.
  - Video read latency constant `BG_RD_LAT`=2.
- Sub-module `bg_dpram`: inferred true dual-port block RAM with registered outputs.
  - Port A: 32 bit with byte enables.
  - Port B: 32-bit read-only.
  - No reset on the array.
- Top level holds the Avalon decode, register file, VS edge detect and swap logic, read pipelines, and the video lane mux.

## Test plan
1. Write 0xA1B2C3D4 to word 5 with BE=4'hF, then BE=4'b0010 with data 0x0000EE00, read word 5 → 0xA1B2EED4 valid exactly 2 cycles after the read.
2. Back-bank fill of word 3 = 0x44332211, request swap, pulse `VGA_VS` low → STATUS=0x1. Video addr 12..15 → bytes 0x11, 0x22, 0x33, 0x44, each 2 cycles after its address.
3. Without a swap request, 3 VS falling edges → FRAME=3, STATUS=0x0. Write CTRL=0x2 → FRAME=0.
4. Swap request written on the exact cycle of the VS edge → STATUS=0x2 after the edge; next edge → STATUS=0x1.
5. Set `swap_pending`, assert `Reset` asynchronously mid-frame → STATUS=0, FRAME=0, readdata=0, `vga_port_backgrounddata`=0 immediately. The next VS edge causes no swap.
6. `AVL_READ` and `AVL_WRITE` asserted together on word 7 with 0x12345678 → readdata 0 in that slot. A subsequent read of word 7 returns 0x12345678.
